// File: rtl/bg_write_sched_if.sv
// Producer-side write request bundle for the background tile-RAM write scheduler.
interface bg_write_sched_if #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/bg_write_sched.sv
// Round-robin time-sliced arbiter for the background tile-RAM write port, with a full-map clear sweep.
// Optional macro BG_SCHED_SKIP_IDLE_EN: a slot whose owner has no valid request ends immediately.
module bg_write_sched #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1200,
  parameter int SLOT_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SLOT_W-1:0] slot_len,
  bg_write_sched_if.slave   req,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic [3:0]        cur_ch,
  output logic              round_done
);
  typedef enum logic {SERVE, CLEAR} state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] len_q;
  logic [SLOT_W-1:0] len_now;
  logic [SLOT_W-1:0] eff_len;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              cur_valid;
  logic              hs;
  logic              slot_end;
  logic              last_ch;
  logic [3:0]        next_ch;

  always_comb begin
    cur_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == 4'(k)) begin
        cur_valid = req.req_valid[k];
        sel_addr  = req.req_addr[k*ADDR_W +: ADDR_W];
        sel_data  = req.req_data[k*DATA_W +: DATA_W];
      end
    end

    // Slot length is taken live at the slot's first cycle and held for the rest of it.
    len_now = (slot_len == '0) ? SLOT_W'(1) : slot_len;
    eff_len = (slot_cnt == '0) ? len_now : len_q;

    hs = (state == SERVE) && cur_valid && !reset;
`ifdef BG_SCHED_SKIP_IDLE_EN
    slot_end = (slot_cnt == eff_len - SLOT_W'(1)) || !cur_valid;
`else
    slot_end = (slot_cnt == eff_len - SLOT_W'(1));
`endif
    last_ch = (cur_ch == 4'(NUM_CH - 1));
    next_ch = last_ch ? 4'd0 : cur_ch + 4'd1;

    round_done = (state == SERVE) && slot_end && last_ch && !reset;

    req.req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == 4'(k)) req.req_ready[k] = hs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SERVE;
      cur_ch     <= '0;
      slot_cnt   <= '0;
      len_q      <= '0;
      clr_ptr    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      clear_busy <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        SERVE: begin
          if (hs) begin
            ram_we   <= 1'b1;
            ram_addr <= sel_addr;
            ram_data <= sel_data;
          end
          if (slot_cnt == '0) len_q <= len_now;
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_ptr    <= '0;
          end else if (slot_end) begin
            slot_cnt <= '0;
            cur_ch   <= next_ch;
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end
        CLEAR: begin
          ram_we   <= 1'b1;
          ram_addr <= clr_ptr;
          ram_data <= '0;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            clr_ptr    <= '0;
            clear_busy <= 1'b0;
            state      <= SERVE;
            cur_ch     <= '0;
            slot_cnt   <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: state <= SERVE;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_write_sched.sv
// Randomized bench for bg_write_sched against a slot/remaining-cycles reference model.
module tb_bg_write_sched;
  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DEP = 1200;
  localparam int SW  = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_start = 1'b0;
  logic [SW-1:0] slot_len = 12'd4;
  logic          clear_busy, ram_we, round_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [3:0]    cur_ch;

  bg_write_sched_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bg_write_sched #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .SLOT_W(SW)) dut (
    .clk(clk), .reset(reset), .slot_len(slot_len), .req(bus),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cur_ch(cur_ch), .round_done(round_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: owner channel, cycles left in slot, sweep progress, expected registered write
  int            m_ch, m_left, m_ptr;
  bit            m_start, m_clear;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ch = 0; m_left = 0; m_ptr = 0; m_start = 1; m_clear = 0;
    e_we = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic rand_inputs(input int pv);
    for (int k = 0; k < NCH; k++) begin
      bus.req_valid[k] = ($urandom_range(99) < pv);
      bus.req_addr[k*AW +: AW] = AW'($urandom);
      bus.req_data[k*DW +: DW] = $urandom;
    end
  endtask

  task automatic step();
    int rem;
    bit v, end_slot;
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    check("ram_we", 64'(ram_we), 64'(e_we));
    check("ram_addr", 64'(ram_addr), 64'(e_addr));
    check("ram_data", 64'(ram_data), 64'(e_data));
    check("clear_busy", 64'(clear_busy), 64'(m_clear));
    if (!m_clear) begin
      rem = m_start ? ((slot_len == 0) ? 1 : int'(slot_len)) : m_left;
      v = bus.req_valid[m_ch];
      exp_rdy = v ? NCH'(1 << m_ch) : '0;
      end_slot = (rem == 1);
`ifdef BG_SCHED_SKIP_IDLE_EN
      if (!v) end_slot = 1;
`endif
      check("cur_ch", 64'(cur_ch), 64'(m_ch));
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("round_done", 64'(round_done), 64'(end_slot && (m_ch == NCH - 1)));
      e_we = v;
      if (v) begin
        e_addr = bus.req_addr[m_ch*AW +: AW];
        e_data = bus.req_data[m_ch*DW +: DW];
      end
      if (clear_start) begin
        m_clear = 1; m_ptr = 0;
      end else if (end_slot) begin
        m_ch = (m_ch + 1) % NCH; m_start = 1;
      end else begin
        m_left = rem - 1; m_start = 0;
      end
    end else begin
      check("ready_in_clear", 64'(bus.req_ready), 64'(0));
      check("round_in_clear", 64'(round_done), 64'(0));
      e_we = 1; e_addr = AW'(m_ptr); e_data = '0;
      m_ptr++;
      if (m_ptr == DEP) begin
        m_clear = 0; m_ch = 0; m_start = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(ram_we), 64'(0));
    check({tag, "_addr"}, 64'(ram_addr), 64'(0));
    check({tag, "_data"}, 64'(ram_data), 64'(0));
    check({tag, "_ch"}, 64'(cur_ch), 64'(0));
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_round"}, 64'(round_done), 64'(0));
    check({tag, "_busy"}, 64'(clear_busy), 64'(0));
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    clear_start = 1'b0;
    bus.req_valid = '1;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    bus.req_valid = '1;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    reset = 1'b0;

    // rotation with all channels busy and distinct addresses
    slot_len = 12'd4;
    for (int i = 0; i < 16; i++) begin
      rand_inputs(100);
      step();
    end

    // zero length behaves as one cycle per slot
    slot_len = 12'd0;
    for (int i = 0; i < 9; i++) begin
      rand_inputs(70);
      step();
    end

    // length change mid-slot only affects the following slot
    slot_len = 12'd4;
    guard = 0;
    while (!m_start && guard < 20) begin rand_inputs(100); step(); guard++; end
    check("wait_slot_start", 64'(m_start), 64'(1));
    rand_inputs(100); step();
    slot_len = 12'd2;
    for (int i = 0; i < 12; i++) begin rand_inputs(100); step(); end

    // random traffic with occasional slot length changes and a mid-slot reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19) == 0) slot_len = SW'($urandom_range(6));
      rand_inputs(60);
      step();
      if (i == 300) mid_reset("slot_rst");
    end

    // clear collides with a ch1 handshake; second clear during sweep is ignored
    slot_len = 12'd3;
    guard = 0;
    while (m_ch != 1 && guard < 20) begin rand_inputs(50); step(); guard++; end
    check("wait_ch1", 64'(m_ch), 64'(1));
    rand_inputs(50);
    bus.req_valid = '1;
    bus.req_addr[1*AW +: AW] = 16'h0055;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 100; i++) begin rand_inputs(50); step(); end
    clear_start = 1'b1;
    rand_inputs(50); step();
    clear_start = 1'b0;
    guard = 0;
    while (m_clear && guard < DEP + 10) begin rand_inputs(50); step(); guard++; end
    check("sweep_done", 64'(m_clear), 64'(0));
    for (int i = 0; i < 30; i++) begin rand_inputs(80); step(); end

    // reset in the middle of a sweep
    clear_start = 1'b1;
    rand_inputs(50); step();
    clear_start = 1'b0;
    for (int i = 0; i < 50; i++) begin rand_inputs(50); step(); end
    mid_reset("clear_rst");
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(29) == 0) slot_len = SW'($urandom_range(5));
      rand_inputs(60);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
